sdio_arbiter: RTL and testbench



---
 rtl/sdio_arbiter_if.sv | 29 ++
 rtl/sdio_arbiter.sv | 175 +++++++++++++++++
 tb/tb_sdio_arbiter.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sdio_arbiter_if.sv
// sdio_arbiter_if
// Groups the request/grant handshake, the bus-switch select and the status
// pulses between two SDIO hosts and the sdio_arbiter.
//   req_a, req_b         level requests from host A / host B
//   gnt_a, gnt_b         ownership grants back to the hosts
//   sdio_cs              bus switch select (0 = A, 1 = B)
//   busy                 arbiter is not idle
//   timeout_a, timeout_b one-cycle pulse when a grant is revoked by timeout
// Modports: master = host side (drives requests), slave = arbiter side.
interface sdio_arbiter_if;
  logic req_a;
  logic req_b;
  logic gnt_a;
  logic gnt_b;
  logic sdio_cs;
  logic busy;
  logic timeout_a;
  logic timeout_b;

  modport master (
    output req_a, req_b,
    input  gnt_a, gnt_b, sdio_cs, busy, timeout_a, timeout_b
  );

  modport slave (
    input  req_a, req_b,
    output gnt_a, gnt_b, sdio_cs, busy, timeout_a, timeout_b
  );
endinterface

// File: rtl/sdio_arbiter.sv
// sdio_arbiter
// Shares one physical SD card bus between two SDIO hosts. Every change of
// ownership is sequenced as release -> guard idle time -> select change ->
// settle time -> grant, so the card never sees a glitch on clock or command
// during the handover. A hold timeout stops one host starving the other.
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    sdio_arbiter_if.slave (requests in; grants, select, status out)
// Parameters:
//   SETTLE_CYCLES   clocks between a select change and the grant (>= 1)
//   GUARD_CYCLES    idle clocks after a grant is removed (>= 1)
//   TIMEOUT_CYCLES  max hold while the other side requests; 0 disables
//   CNT_W           counter width, must hold all three counts above
module sdio_arbiter #(
  parameter int SETTLE_CYCLES  = 4,
  parameter int GUARD_CYCLES   = 8,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int CNT_W          = 20
) (
  input logic           clk,
  input logic           rst_n,
  sdio_arbiter_if.slave bus
);

  localparam logic [CNT_W-1:0] SETTLE_LOAD  = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GUARD_LOAD   = CNT_W'(GUARD_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam bit               TIMEOUT_EN   = (TIMEOUT_CYCLES != 0);

  // Side encoding follows sdio_cs: 0 = host A, 1 = host B.
  localparam logic SIDE_A = 1'b0;
  localparam logic SIDE_B = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    OWN    = 2'd2,
    GUARD  = 2'd3
  } state_t;

  state_t           state, state_next;
  logic             owner, owner_next;
  logic             last_owner, last_owner_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             sdio_cs_q, sdio_cs_next;
  logic             timeout_hit;

  logic gnt_a_q, gnt_b_q, busy_q, timeout_a_q, timeout_b_q;
  logic gnt_a_next, gnt_b_next, busy_next, timeout_a_next, timeout_b_next;

  logic own_req;
  logic other_req;

  assign own_req   = (owner == SIDE_B) ? bus.req_b : bus.req_a;
  assign other_req = (owner == SIDE_B) ? bus.req_a : bus.req_b;

  // State register plus all registered outputs. last_owner resets to B so
  // that A wins the very first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      owner       <= SIDE_A;
      last_owner  <= SIDE_B;
      cnt         <= '0;
      sdio_cs_q   <= 1'b0;
      gnt_a_q     <= 1'b0;
      gnt_b_q     <= 1'b0;
      busy_q      <= 1'b0;
      timeout_a_q <= 1'b0;
      timeout_b_q <= 1'b0;
    end else begin
      state       <= state_next;
      owner       <= owner_next;
      last_owner  <= last_owner_next;
      cnt         <= cnt_next;
      sdio_cs_q   <= sdio_cs_next;
      gnt_a_q     <= gnt_a_next;
      gnt_b_q     <= gnt_b_next;
      busy_q      <= busy_next;
      timeout_a_q <= timeout_a_next;
      timeout_b_q <= timeout_b_next;
    end
  end

  // Next-state logic. cnt is shared: settle countdown, hold counter while
  // owning, and guard countdown. The select only moves when leaving IDLE,
  // and the full settle runs even if the select already matches.
  always_comb begin
    state_next      = state;
    owner_next      = owner;
    last_owner_next = last_owner;
    cnt_next        = cnt;
    sdio_cs_next    = sdio_cs_q;
    timeout_hit     = 1'b0;

    case (state)
      IDLE: begin
        if (bus.req_a || bus.req_b) begin
          if (bus.req_a && bus.req_b) begin
            owner_next = ~last_owner;
          end else begin
            owner_next = bus.req_b;
          end
          sdio_cs_next = owner_next;
          cnt_next     = SETTLE_LOAD;
          state_next   = SETTLE;
        end
      end

      SETTLE: begin
        if (!own_req) begin
          last_owner_next = owner;
          cnt_next        = GUARD_LOAD;
          state_next      = GUARD;
        end else if (cnt == '0) begin
          cnt_next   = '0;
          state_next = OWN;
        end else begin
          cnt_next = cnt - 1'b1;
        end
      end

      OWN: begin
        // A release on the same edge as a timeout wins, so it is tested first.
        if (!own_req) begin
          last_owner_next = owner;
          cnt_next        = GUARD_LOAD;
          state_next      = GUARD;
        end else if (TIMEOUT_EN && other_req && (cnt == TIMEOUT_LAST)) begin
          timeout_hit     = 1'b1;
          last_owner_next = owner;
          cnt_next        = GUARD_LOAD;
          state_next      = GUARD;
        end else if (other_req) begin
          if (cnt != '1) begin
            cnt_next = cnt + 1'b1;
          end
        end else begin
          cnt_next = '0;
        end
      end

      GUARD: begin
        if (cnt == '0) begin
          state_next = IDLE;
        end else begin
          cnt_next = cnt - 1'b1;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Output decode, evaluated on the next state so that every output is a
  // plain register with no input-to-output combinational path.
  always_comb begin
    gnt_a_next     = (state_next == OWN) && (owner_next == SIDE_A);
    gnt_b_next     = (state_next == OWN) && (owner_next == SIDE_B);
    busy_next      = (state_next != IDLE);
    timeout_a_next = timeout_hit && (owner == SIDE_A);
    timeout_b_next = timeout_hit && (owner == SIDE_B);
  end

  assign bus.gnt_a     = gnt_a_q;
  assign bus.gnt_b     = gnt_b_q;
  assign bus.sdio_cs   = sdio_cs_q;
  assign bus.busy      = busy_q;
  assign bus.timeout_a = timeout_a_q;
  assign bus.timeout_b = timeout_b_q;

endmodule

// File: tb/tb_sdio_arbiter.sv
// tb_sdio_arbiter
// Directed bench for sdio_arbiter. The main instance uses a 16-cycle hold
// timeout so the timeout path is reachable quickly; a second instance with
// the timeout disabled shows a host can hold the bus indefinitely.
module tb_sdio_arbiter;

  logic clk;
  logic rst_n;

  int checks;
  int errors;

  sdio_arbiter_if bus ();
  sdio_arbiter_if bus0 ();

  sdio_arbiter #(
    .SETTLE_CYCLES (4),
    .GUARD_CYCLES  (8),
    .TIMEOUT_CYCLES(16),
    .CNT_W         (20)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  sdio_arbiter #(
    .SETTLE_CYCLES (4),
    .GUARD_CYCLES  (8),
    .TIMEOUT_CYCLES(0),
    .CNT_W         (20)
  ) dut0 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n rising edges and land 1 time unit after the last one, so
  // outputs are sampled away from the edge and new inputs are set up for
  // the following edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic a, input logic b);
    bus.req_a = a;
    bus.req_b = b;
  endtask

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  initial begin
    logic a_lvl, b_lvl, prev_cs, prev_busy;
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    apply_stimulus(1'b0, 1'b0);
    bus0.req_a = 1'b0;
    bus0.req_b = 1'b0;

    // Reset values
    #1;
    check_output("rst_gnt_a", bus.gnt_a, 0);
    check_output("rst_gnt_b", bus.gnt_b, 0);
    check_output("rst_cs", bus.sdio_cs, 0);
    check_output("rst_busy", bus.busy, 0);
    check_output("rst_to_a", bus.timeout_a, 0);
    check_output("rst_to_b", bus.timeout_b, 0);
    tick(2);
    rst_n = 1'b1;
    tick(1);

    // Single request from A, 20 cycles long
    $display("[TB] single request");
    apply_stimulus(1'b1, 1'b0);
    tick(1);
    check_output("single_cs", bus.sdio_cs, 0);
    check_output("single_busy", bus.busy, 1);
    check_output("single_gnt_early", bus.gnt_a, 0);
    tick(3);
    check_output("single_gnt_e3", bus.gnt_a, 0);
    tick(1);
    check_output("single_gnt_e4", bus.gnt_a, 1);
    check_output("single_gnt_b", bus.gnt_b, 0);
    tick(15);
    check_output("single_gnt_hold", bus.gnt_a, 1);
    apply_stimulus(1'b0, 1'b0);
    tick(1);
    check_output("single_release", bus.gnt_a, 0);
    check_output("single_guard_busy0", bus.busy, 1);
    for (int i = 1; i < 8; i++) begin
      tick(1);
      check_output("single_guard_busy", bus.busy, 1);
    end
    tick(1);
    check_output("single_idle_busy", bus.busy, 0);

    // Tie from reset: A first, then B round-robin
    $display("[TB] tie and round-robin");
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    apply_stimulus(1'b1, 1'b1);
    tick(1);
    check_output("tie_cs_a", bus.sdio_cs, 0);
    tick(4);
    check_output("tie_gnt_a", bus.gnt_a, 1);
    check_output("tie_gnt_b_low", bus.gnt_b, 0);
    tick(3);
    apply_stimulus(1'b0, 1'b1);
    tick(1);
    check_output("tie_rel_gnt_a", bus.gnt_a, 0);
    check_output("tie_rel_gnt_b", bus.gnt_b, 0);
    tick(8);
    check_output("tie_cs_hold_r8", bus.sdio_cs, 0);
    check_output("tie_idle_r8", bus.busy, 0);
    tick(1);
    check_output("tie_cs_b_r9", bus.sdio_cs, 1);
    tick(3);
    check_output("tie_gnt_b_r12", bus.gnt_b, 0);
    tick(1);
    check_output("tie_gnt_b_r13", bus.gnt_b, 1);
    apply_stimulus(1'b0, 1'b0);
    tick(1);
    check_output("tie_b_release", bus.gnt_b, 0);
    tick(9);
    check_output("tie_back_idle", bus.busy, 0);

    // Abort in SETTLE: B drops its request two clocks into SETTLE
    $display("[TB] abort in settle");
    apply_stimulus(1'b0, 1'b1);
    tick(1);
    check_output("abort_cs", bus.sdio_cs, 1);
    tick(1);
    check_output("abort_gnt_s1", bus.gnt_b, 0);
    apply_stimulus(1'b0, 1'b0);
    tick(1);
    check_output("abort_gnt_g0", bus.gnt_b, 0);
    check_output("abort_busy_g0", bus.busy, 1);
    for (int i = 1; i < 8; i++) begin
      tick(1);
      check_output("abort_gnt_guard", bus.gnt_b, 0);
      check_output("abort_busy_guard", bus.busy, 1);
    end
    tick(1);
    check_output("abort_idle", bus.busy, 0);
    check_output("abort_cs_hold", bus.sdio_cs, 1);

    // Timeout: A holds while B requests continuously
    $display("[TB] timeout");
    apply_stimulus(1'b1, 1'b0);
    tick(5);
    check_output("to_gnt_a", bus.gnt_a, 1);
    apply_stimulus(1'b1, 1'b1);
    for (int i = 1; i < 16; i++) begin
      tick(1);
      check_output("to_gnt_a_hold", bus.gnt_a, 1);
      check_output("to_pulse_early", bus.timeout_a, 0);
    end
    tick(1);
    check_output("to_gnt_a_revoked", bus.gnt_a, 0);
    check_output("to_pulse_a", bus.timeout_a, 1);
    check_output("to_pulse_b_quiet", bus.timeout_b, 0);
    tick(1);
    check_output("to_pulse_a_end", bus.timeout_a, 0);
    tick(11);
    check_output("to_gnt_b_r12", bus.gnt_b, 0);
    tick(1);
    check_output("to_gnt_b_r13", bus.gnt_b, 1);
    check_output("to_cs_b", bus.sdio_cs, 1);
    check_output("to_gnt_a_low", bus.gnt_a, 0);
    apply_stimulus(1'b0, 1'b0);
    tick(10);
    check_output("to_back_idle", bus.busy, 0);

    // Timeout disabled: A keeps the bus indefinitely
    $display("[TB] timeout disabled");
    bus0.req_a = 1'b1;
    tick(5);
    check_output("notimeout_gnt_a", bus0.gnt_a, 1);
    bus0.req_b = 1'b1;
    tick(40);
    check_output("notimeout_hold_a", bus0.gnt_a, 1);
    check_output("notimeout_gnt_b", bus0.gnt_b, 0);
    check_output("notimeout_pulse", bus0.timeout_a, 0);
    bus0.req_a = 1'b0;
    bus0.req_b = 1'b0;

    // Asynchronous reset in the middle of a B grant
    $display("[TB] reset mid-own");
    apply_stimulus(1'b0, 1'b1);
    tick(5);
    check_output("rstown_gnt_b", bus.gnt_b, 1);
    check_output("rstown_cs", bus.sdio_cs, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_output("rstown_gnt_b_async", bus.gnt_b, 0);
    check_output("rstown_cs_async", bus.sdio_cs, 0);
    check_output("rstown_busy_async", bus.busy, 0);
    apply_stimulus(1'b0, 1'b0);
    tick(1);
    rst_n = 1'b1;
    apply_stimulus(1'b1, 1'b0);
    tick(4);
    check_output("rstown_gnt_a_e3", bus.gnt_a, 0);
    tick(1);
    check_output("rstown_gnt_a_e4", bus.gnt_a, 1);
    apply_stimulus(1'b0, 1'b0);
    tick(10);

    // Random requests with invariant checks every cycle
    $display("[TB] random invariants");
    a_lvl = 1'b0;
    b_lvl = 1'b0;
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(7) == 0) a_lvl = ~a_lvl;
      if ($urandom_range(7) == 0) b_lvl = ~b_lvl;
      apply_stimulus(a_lvl, b_lvl);
      prev_cs   = bus.sdio_cs;
      prev_busy = bus.busy;
      tick(1);
      check_output("inv_dual_grant", bus.gnt_a & bus.gnt_b, 0);
      check_output("inv_gnt_a_cs", bus.gnt_a & bus.sdio_cs, 0);
      check_output("inv_gnt_b_cs", bus.gnt_b & ~bus.sdio_cs, 0);
      if (prev_busy) check_output("inv_cs_stable", bus.sdio_cs, prev_cs);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
